hgc_crtc_programmer: RTL and testbench

- ISA I/O bus initiator that performs a complete Hercules mode-set against the HGC responder.
- Sequence: unlock the config switch, blank video, load all 12 MC6845 registers through the index/data port pair, poll the status port for vertical sync, then enable video.
- Sits on the ISA side of the core and stands in for BIOS INT10h mode-set code. Used for power-on bring-up and for text/graphics switching from front-end control.

---
 rtl/hgc_crtc_programmer.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_hgc_crtc_programmer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hgc_crtc_programmer.sv
`default_nettype none
// ============================================================================
// Module   : hgc_crtc_programmer
// Purpose  : ISA I/O bus initiator that performs a full Hercules mode-set:
//            unlock config, blank video, load the 12 MC6845 registers via the
//            index/data ports, wait for vertical sync, then enable video.
// Revision : 1.0 - initial release
// ============================================================================
module hgc_crtc_programmer #(
    parameter logic [15:0] IO_BASE_ADDR = 16'h3b0,
    parameter int          SETUP_CYC    = 1,
    parameter int          STROBE_CYC   = 4,
    parameter int          HOLD_CYC     = 1,
    parameter logic [15:0] POLL_LIMIT   = 16'd65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode_graphics,
    input  logic        page_sel,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic [14:0] bus_a,
    output logic [7:0]  bus_d_out,
    input  logic [7:0]  bus_d_in,
    output logic        bus_iow_l,
    output logic        bus_ior_l,
    output logic        bus_aen
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Step numbering: 0 unlock, 1 blank, 2..25 index/data pairs, 26 poll, 27 enable.
    localparam logic [4:0]  c_step_poll   = 5'd26;
    localparam logic [4:0]  c_step_last   = 5'd27;
    localparam logic [15:0] c_setup_last  = 16'(SETUP_CYC - 1);
    localparam logic [15:0] c_strobe_last = 16'(STROBE_CYC - 1);
    localparam logic [15:0] c_hold_last   = 16'(HOLD_CYC - 1);
    // A zero limit would never expire; treat it as a single read.
    localparam logic [15:0] c_poll_limit  = (POLL_LIMIT == 16'd0) ? 16'd1 : POLL_LIMIT;

    state_t      r_state, w_state;
    logic [15:0] r_cnt, w_cnt;
    logic [4:0]  r_step, w_step, w_nstep;
    logic        r_mode, w_mode;
    logic        r_page, w_page;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic        r_timeout, w_timeout;
    logic [15:0] r_poll_cnt, w_poll_cnt;
    logic        r_vsync_n, w_vsync_n;
    logic [14:0] r_a, w_a;
    logic [7:0]  r_d, w_d;
    logic        r_iow_l, w_iow_l;
    logic        r_ior_l, w_ior_l;
    logic        r_aen, w_aen;

    logic        w_is_read;
    logic [15:0] w_poll_inc;
    logic        w_unused;

    // Only the vsync flag (bit 7) of the status port matters here.
    assign w_unused   = &{1'b0, bus_d_in[6:0]};
    assign w_is_read  = (r_step == c_step_poll);
    assign w_poll_inc = r_poll_cnt + 16'd1;

    // Port offset within the HGC window for each step.
    function automatic logic [3:0] f_offset(input logic [4:0] step);
        if (step == 5'd0)
            f_offset = 4'hF;
        else if (step == 5'd1 || step == c_step_last)
            f_offset = 4'h8;
        else if (step == c_step_poll)
            f_offset = 4'hA;
        else if (step[0] == 1'b0)
            f_offset = 4'h4;        // even steps 2..24 select the CRTC index
        else
            f_offset = 4'h5;        // odd steps 3..25 write the CRTC data
    endfunction

    // Bits [14:0] of base + offset; bit 15 of the sum is never used.
    function automatic logic [14:0] f_addr(input logic [4:0] step);
        f_addr = IO_BASE_ADDR[14:0] + {11'd0, f_offset(step)};
    endfunction

    // MC6845 register tables for the two video modes.
    function automatic logic [7:0] f_crtc(input logic [3:0] idx, input logic gfx);
        logic [7:0] t, g;
        case (idx)
            4'd0:    begin t = 8'h61; g = 8'h35; end
            4'd1:    begin t = 8'h50; g = 8'h2D; end
            4'd2:    begin t = 8'h52; g = 8'h2E; end
            4'd3:    begin t = 8'h0F; g = 8'h07; end
            4'd4:    begin t = 8'h19; g = 8'h5B; end
            4'd5:    begin t = 8'h06; g = 8'h02; end
            4'd6:    begin t = 8'h19; g = 8'h57; end
            4'd7:    begin t = 8'h19; g = 8'h57; end
            4'd8:    begin t = 8'h02; g = 8'h02; end
            4'd9:    begin t = 8'h0D; g = 8'h03; end
            4'd10:   begin t = 8'h0B; g = 8'h00; end
            4'd11:   begin t = 8'h0C; g = 8'h00; end
            default: begin t = 8'h00; g = 8'h00; end
        endcase
        f_crtc = gfx ? g : t;
    endfunction

    // Write data for each step (the poll read drives zero).
    function automatic logic [7:0] f_data(input logic [4:0] step, input logic gfx,
                                          input logic page);
        logic [3:0] idx;
        idx = 4'((step - 5'd2) >> 1);
        if (step == 5'd0)
            f_data = 8'h03;
        else if (step == 5'd1)
            f_data = gfx ? 8'h02 : 8'h20;
        else if (step == c_step_last)
            f_data = gfx ? (page ? 8'h8A : 8'h0A) : 8'h28;
        else if (step == c_step_poll)
            f_data = 8'h00;
        else if (step[0] == 1'b0)
            f_data = {4'h0, idx};
        else
            f_data = f_crtc(idx, gfx);
    endfunction

    // Next-state and next-output logic; bus outputs are registered so the
    // strobes come straight from flops and cannot glitch.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_step     = r_step;
        w_nstep    = r_step;
        w_mode     = r_mode;
        w_page     = r_page;
        w_busy     = r_busy;
        w_done     = r_done;
        w_timeout  = r_timeout;
        w_poll_cnt = r_poll_cnt;
        w_vsync_n  = r_vsync_n;
        w_a        = r_a;
        w_d        = r_d;
        w_iow_l    = 1'b1;
        w_ior_l    = 1'b1;
        w_aen      = r_aen;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mode     = mode_graphics;
                    w_page     = page_sel;
                    w_done     = 1'b0;
                    w_timeout  = 1'b0;
                    w_busy     = 1'b1;
                    w_step     = 5'd0;
                    w_poll_cnt = 16'd0;
                    w_cnt      = 16'd0;
                    w_state    = S_SETUP;
                    w_aen      = 1'b0;
                    w_a        = f_addr(5'd0);
                    w_d        = f_data(5'd0, mode_graphics, page_sel);
                end
            end

            S_SETUP: begin
                if (r_cnt == c_setup_last) begin
                    w_cnt   = 16'd0;
                    w_state = S_STROBE;
                    w_iow_l = w_is_read;
                    w_ior_l = !w_is_read;
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end

            S_STROBE: begin
                if (r_cnt == c_strobe_last) begin
                    w_cnt   = 16'd0;
                    w_state = S_HOLD;
                    if (w_is_read)
                        w_vsync_n = bus_d_in[7];
                end else begin
                    w_cnt   = r_cnt + 16'd1;
                    w_iow_l = r_iow_l;
                    w_ior_l = r_ior_l;
                end
            end

            S_HOLD: begin
                if (r_cnt == c_hold_last) begin
                    w_cnt = 16'd0;
                    if (r_step == c_step_last) begin
                        w_state = S_DONE;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_aen   = 1'b1;
                    end else begin
                        if (w_is_read) begin
                            if (!r_vsync_n) begin
                                w_nstep = c_step_last;
                            end else begin
                                w_poll_cnt = w_poll_inc;
                                if (w_poll_inc >= c_poll_limit) begin
                                    w_timeout = 1'b1;
                                    w_nstep   = c_step_last;
                                end else begin
                                    w_nstep = c_step_poll;
                                end
                            end
                        end else begin
                            w_nstep = r_step + 5'd1;
                        end
                        w_step  = w_nstep;
                        w_state = S_SETUP;
                        w_a     = f_addr(w_nstep);
                        w_d     = f_data(w_nstep, r_mode, r_page);
                    end
                end else begin
                    w_cnt = r_cnt + 16'd1;
                end
            end

            S_DONE: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset returns the bus to idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 16'd0;
            r_step     <= 5'd0;
            r_mode     <= 1'b0;
            r_page     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_poll_cnt <= 16'd0;
            r_vsync_n  <= 1'b1;
            r_a        <= 15'd0;
            r_d        <= 8'd0;
            r_iow_l    <= 1'b1;
            r_ior_l    <= 1'b1;
            r_aen      <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_step     <= w_step;
            r_mode     <= w_mode;
            r_page     <= w_page;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_timeout  <= w_timeout;
            r_poll_cnt <= w_poll_cnt;
            r_vsync_n  <= w_vsync_n;
            r_a        <= w_a;
            r_d        <= w_d;
            r_iow_l    <= w_iow_l;
            r_ior_l    <= w_ior_l;
            r_aen      <= w_aen;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign timeout_err = r_timeout;
    assign bus_a       = r_a;
    assign bus_d_out   = r_d;
    assign bus_iow_l   = r_iow_l;
    assign bus_ior_l   = r_ior_l;
    assign bus_aen     = r_aen;

endmodule
`default_nettype wire

// File: tb/tb_hgc_crtc_programmer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hgc_crtc_programmer
// Purpose  : Self-checking bench for hgc_crtc_programmer. Two instances: the
//            default build and one with STROBE_CYC=2 / POLL_LIMIT=3. A bus
//            monitor logs every I/O cycle; a mode-set model builds the
//            expected cycle list from the register tables.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hgc_crtc_programmer;

    localparam logic [15:0] BASE = 16'h3b0;

    typedef struct {
        bit          rd;
        logic [14:0] a;
        logic [7:0]  d;
        int          len;
    } rec_t;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       start = '0;
    logic [1:0]       mode  = '0;
    logic [1:0]       page  = '0;
    wire  [1:0]       busy, done, tmo, iow_l, ior_l, aen;
    wire  [1:0][14:0] a;
    wire  [1:0][7:0]  dout;
    wire  [1:0][7:0]  din;
    logic [1:0][6:0]  rnd = '0;

    int   rd_seen[2];
    int   fail_reads[2];
    int   stab_err[2];
    rec_t log0[$];
    rec_t log1[$];
    rec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // Status responder: bit7 high (no vsync) for the first fail_reads reads.
    assign din[0] = {(rd_seen[0] < fail_reads[0]), rnd[0]};
    assign din[1] = {(rd_seen[1] < fail_reads[1]), rnd[1]};

    hgc_crtc_programmer u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]),
        .mode_graphics(mode[0]), .page_sel(page[0]),
        .busy(busy[0]), .done(done[0]), .timeout_err(tmo[0]),
        .bus_a(a[0]), .bus_d_out(dout[0]), .bus_d_in(din[0]),
        .bus_iow_l(iow_l[0]), .bus_ior_l(ior_l[0]), .bus_aen(aen[0])
    );

    hgc_crtc_programmer #(.STROBE_CYC(2), .POLL_LIMIT(16'd3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]),
        .mode_graphics(mode[1]), .page_sel(page[1]),
        .busy(busy[1]), .done(done[1]), .timeout_err(tmo[1]),
        .bus_a(a[1]), .bus_d_out(dout[1]), .bus_d_in(din[1]),
        .bus_iow_l(iow_l[1]), .bus_ior_l(ior_l[1]), .bus_aen(aen[1])
    );

    // Bus monitor: logs each strobe window and counts address/data changes
    // between the setup sample and the hold sample, or strobes without aen low.
    initial begin : mon
        bit          lo[2];
        bit          prev_lo[2];
        logic [14:0] pa[2], ca[2];
        logic [7:0]  pd[2], cd[2];
        bit          crd[2];
        int          clen[2];
        rec_t        r;
        prev_lo = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                lo[k] = !(iow_l[k] && ior_l[k]);
                if (lo[k]) begin
                    if (!prev_lo[k]) begin
                        ca[k] = a[k]; cd[k] = dout[k]; crd[k] = !ior_l[k]; clen[k] = 1;
                        if (a[k] !== pa[k] || dout[k] !== pd[k]) stab_err[k]++;
                    end else begin
                        clen[k]++;
                        if (a[k] !== ca[k] || dout[k] !== cd[k]) stab_err[k]++;
                    end
                    if (aen[k] !== 1'b0) stab_err[k]++;
                end else if (prev_lo[k]) begin
                    if (a[k] !== ca[k] || dout[k] !== cd[k]) stab_err[k]++;
                    r = '{crd[k], ca[k], cd[k], clen[k]};
                    if (k == 0) log0.push_back(r); else log1.push_back(r);
                    if (crd[k]) rd_seen[k]++;
                    rnd[k] = 7'($urandom);
                end
                prev_lo[k] = lo[k]; pa[k] = a[k]; pd[k] = dout[k];
            end
        end
    end

    // Reference mode-set: the ordered list of I/O cycles a correct programmer makes.
    function automatic void build_exp(input bit gfx, input bit pg, input int fails,
                                      input int limit);
        logic [7:0] t_txt [12];
        logic [7:0] t_gfx [12];
        int nrd;
        int eff;
        t_txt = '{8'h61, 8'h50, 8'h52, 8'h0F, 8'h19, 8'h06, 8'h19, 8'h19, 8'h02, 8'h0D, 8'h0B, 8'h0C};
        t_gfx = '{8'h35, 8'h2D, 8'h2E, 8'h07, 8'h5B, 8'h02, 8'h57, 8'h57, 8'h02, 8'h03, 8'h00, 8'h00};
        exp_q.delete();
        exp_q.push_back('{1'b0, 15'(BASE + 16'hF), 8'h03, 0});
        exp_q.push_back('{1'b0, 15'(BASE + 16'h8), gfx ? 8'h02 : 8'h20, 0});
        for (int r = 0; r < 12; r++) begin
            exp_q.push_back('{1'b0, 15'(BASE + 16'h4), 8'(r), 0});
            exp_q.push_back('{1'b0, 15'(BASE + 16'h5), gfx ? t_gfx[r] : t_txt[r], 0});
        end
        eff = (limit == 0) ? 1 : limit;
        nrd = (fails + 1 < eff) ? fails + 1 : eff;
        for (int i = 0; i < nrd; i++)
            exp_q.push_back('{1'b1, 15'(BASE + 16'hA), 8'h00, 0});
        exp_q.push_back('{1'b0, 15'(BASE + 16'h8), !gfx ? 8'h28 : (pg ? 8'h8A : 8'h0A), 0});
    endfunction

    // Number of logged cycles that differ from the model (read data ignored).
    function automatic int count_diffs(input int k, input int slen);
        int   n;
        int   sz;
        rec_t r;
        n  = 0;
        sz = (k == 0) ? log0.size() : log1.size();
        for (int i = 0; i < exp_q.size() && i < sz; i++) begin
            r = (k == 0) ? log0[i] : log1[i];
            if (r.rd !== exp_q[i].rd || r.a !== exp_q[i].a || r.len != slen ||
                (!r.rd && r.d !== exp_q[i].d))
                n++;
        end
        return n;
    endfunction

    function automatic int log_size(input int k);
        return (k == 0) ? log0.size() : log1.size();
    endfunction

    function automatic rec_t last_rec(input int k);
        rec_t r;
        r = '{1'b0, 15'd0, 8'd0, 0};
        if (k == 0 && log0.size() > 0) r = log0[log0.size() - 1];
        if (k == 1 && log1.size() > 0) r = log1[log1.size() - 1];
        return r;
    endfunction

    function automatic int count_reads(input int k);
        int n;
        n = 0;
        for (int i = 0; i < log_size(k); i++)
            if ((k == 0) ? log0[i].rd : log1[i].rd) n++;
        return n;
    endfunction

    // One mode-set on instance k; returns clocks from the start-sampling edge
    // to done, and the number of clocks busy was low before done.
    task automatic run_seq(input int k, input bit gfx, input bit pg, input int fails,
                           input bit restart, output int cycles, output int busy_gaps);
        @(posedge clk); #1;
        if (k == 0) log0.delete(); else log1.delete();
        rd_seen[k] = 0; stab_err[k] = 0; fail_reads[k] = fails;
        mode[k] = gfx; page[k] = pg; start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0; mode[k] = ~gfx; page[k] = ~pg;
        cycles = 0; busy_gaps = 0;
        while (done[k] !== 1'b1 && cycles < 2000) begin
            if (busy[k] !== 1'b1) busy_gaps++;
            start[k] = (restart && cycles == 20) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            cycles++;
        end
        start[k] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({iow_l[k], ior_l[k], aen[k], busy[k], done[k], tmo[k]} !== 6'b111000) begin
                bad++;
                $display("FAIL reset_ctl dut%0d: got %b want 111000", k,
                         {iow_l[k], ior_l[k], aen[k], busy[k], done[k], tmo[k]});
            end
            total++;
            if ({a[k], dout[k]} !== 23'd0) begin
                bad++;
                $display("FAIL reset_bus dut%0d: got a=%h d=%h want 0", k, a[k], dout[k]);
            end
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({iow_l[0], ior_l[0], aen[0], busy[0]} !== 4'b1110) begin
            bad++;
            $display("FAIL reset_idle: got %b want 1110", {iow_l[0], ior_l[0], aen[0], busy[0]});
        end
    endtask

    task automatic test_text();
        int   cyc, gaps;
        rec_t r;
        run_seq(0, 1'b0, 1'b0, 0, 1'b0, cyc, gaps);
        build_exp(1'b0, 1'b0, 0, 65535);
        total++; if (cyc != 168) begin bad++; $display("FAIL text_latency: got %0d want 168", cyc); end
        total++; if (log0.size() != 28) begin bad++; $display("FAIL text_count: got %0d want 28", log0.size()); end
        total++; if (count_diffs(0, 4) != 0) begin bad++; $display("FAIL text_order: got %0d diffs want 0", count_diffs(0, 4)); end
        r = last_rec(0);
        total++; if (r.a !== 15'h3b8 || r.d !== 8'h28) begin bad++; $display("FAIL text_last: got %h=%h want 3b8=28", r.a, r.d); end
        total++; if ({done[0], busy[0], tmo[0]} !== 3'b100) begin bad++; $display("FAIL text_flags: got %b want 100", {done[0], busy[0], tmo[0]}); end
        total++; if (stab_err[0] != 0 || gaps != 0) begin bad++; $display("FAIL text_stable: got stab=%0d gaps=%0d want 0", stab_err[0], gaps); end
    endtask

    task automatic test_graphics();
        int   cyc, gaps;
        rec_t r;
        run_seq(0, 1'b1, 1'b1, 0, 1'b0, cyc, gaps);
        build_exp(1'b1, 1'b1, 0, 65535);
        total++; if (cyc != 168) begin bad++; $display("FAIL gfx_latency: got %0d want 168", cyc); end
        total++; if (log0.size() != 28 || count_diffs(0, 4) != 0) begin bad++; $display("FAIL gfx_order: got n=%0d diffs=%0d want 28/0", log0.size(), count_diffs(0, 4)); end
        r = last_rec(0);
        total++; if (r.a !== 15'h3b8 || r.d !== 8'h8A) begin bad++; $display("FAIL gfx_last: got %h=%h want 3b8=8a", r.a, r.d); end
    endtask

    task automatic test_random();
        int cyc, gaps, fails;
        bit gfx, pg;
        for (int it = 0; it < 4; it++) begin
            gfx   = 1'($urandom);
            pg    = 1'($urandom);
            fails = int'($urandom_range(0, 4));
            run_seq(0, gfx, pg, fails, 1'b0, cyc, gaps);
            build_exp(gfx, pg, fails, 65535);
            total++;
            if (cyc != 6 * (28 + fails) || log0.size() != exp_q.size() || count_diffs(0, 4) != 0 || tmo[0] !== 1'b0) begin
                bad++;
                $display("FAIL rand_%0d g=%0d p=%0d f=%0d: got cyc=%0d n=%0d diffs=%0d tmo=%b want cyc=%0d n=%0d diffs=0 tmo=0",
                         it, gfx, pg, fails, cyc, log0.size(), count_diffs(0, 4), tmo[0], 6 * (28 + fails), exp_q.size());
            end
        end
    endtask

    task automatic test_poll_retry();
        int cyc, gaps;
        run_seq(0, 1'b0, 1'b0, 5, 1'b0, cyc, gaps);
        build_exp(1'b0, 1'b0, 5, 65535);
        total++; if (count_reads(0) != 6) begin bad++; $display("FAIL poll_reads: got %0d want 6", count_reads(0)); end
        total++; if ({done[0], tmo[0]} !== 2'b10) begin bad++; $display("FAIL poll_flags: got done,tmo=%b want 10", {done[0], tmo[0]}); end
        total++; if (cyc != 198 || count_diffs(0, 4) != 0) begin bad++; $display("FAIL poll_seq: got cyc=%0d diffs=%0d want 198/0", cyc, count_diffs(0, 4)); end
    endtask

    task automatic test_timeout();
        int   cyc, gaps;
        rec_t r;
        run_seq(1, 1'b1, 1'b0, 1000, 1'b0, cyc, gaps);
        build_exp(1'b1, 1'b0, 1000, 3);
        total++; if (count_reads(1) != 3) begin bad++; $display("FAIL tmo_reads: got %0d want 3", count_reads(1)); end
        total++; if ({done[1], tmo[1]} !== 2'b11) begin bad++; $display("FAIL tmo_flags: got done,tmo=%b want 11", {done[1], tmo[1]}); end
        r = last_rec(1);
        total++; if (r.a !== 15'h3b8 || r.d !== 8'h0A) begin bad++; $display("FAIL tmo_last: got %h=%h want 3b8=0a", r.a, r.d); end
        total++; if (cyc != 120 || count_diffs(1, 2) != 0) begin bad++; $display("FAIL tmo_seq: got cyc=%0d diffs=%0d want 120/0", cyc, count_diffs(1, 2)); end
    endtask

    task automatic test_back_to_back();
        int cyc, gaps;
        run_seq(1, 1'b0, 1'b0, 0, 1'b1, cyc, gaps);
        build_exp(1'b0, 1'b0, 0, 3);
        total++; if (cyc != 112) begin bad++; $display("FAIL b2b_latency: got %0d want 112", cyc); end
        total++; if (log1.size() != 28 || count_diffs(1, 2) != 0) begin bad++; $display("FAIL b2b_order: got n=%0d diffs=%0d want 28/0", log1.size(), count_diffs(1, 2)); end
        total++; if (stab_err[1] != 0 || tmo[1] !== 1'b0) begin bad++; $display("FAIL b2b_stable: got stab=%0d tmo=%b want 0/0", stab_err[1], tmo[1]); end
    endtask

    task automatic test_reset_mid();
        int   cyc, gaps, w;
        rec_t r;
        @(posedge clk); #1;
        log0.delete(); rd_seen[0] = 0; fail_reads[0] = 0;
        mode[0] = 1'b0; page[0] = 1'b0; start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        w = 0;
        while (!(log0.size() == 10 && iow_l[0] === 1'b0) && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        total++; if (w >= 200) begin bad++; $display("FAIL mid_reach: got no step-10 strobe within %0d clocks", w); end
        reset = 1'b1;
        #1;
        total++;
        if ({iow_l[0], ior_l[0], aen[0], busy[0]} !== 4'b1110) begin
            bad++;
            $display("FAIL mid_abort: got iow,ior,aen,busy=%b want 1110", {iow_l[0], ior_l[0], aen[0], busy[0]});
        end
        @(posedge clk); #1;
        reset = 1'b0;
        run_seq(0, 1'b0, 1'b0, 0, 1'b0, cyc, gaps);
        build_exp(1'b0, 1'b0, 0, 65535);
        r = (log0.size() > 0) ? log0[0] : '{1'b0, 15'd0, 8'd0, 0};
        total++; if (r.a !== 15'h3bf || r.d !== 8'h03) begin bad++; $display("FAIL mid_first: got %h=%h want 3bf=03", r.a, r.d); end
        total++; if (cyc != 168 || log0.size() != 28 || count_diffs(0, 4) != 0) begin bad++; $display("FAIL mid_rerun: got cyc=%0d n=%0d diffs=%0d want 168/28/0", cyc, log0.size(), count_diffs(0, 4)); end
    endtask

    initial begin
        rd_seen    = '{0, 0};
        fail_reads = '{0, 0};
        stab_err   = '{0, 0};
        test_reset();
        test_text();
        test_graphics();
        test_random();
        test_poll_retry();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
